// File: rtl/branch_unit_if.sv
// branch_unit_if: branch request, flag and PC/commit signals between decoder/comparator and the branch unit
interface branch_unit_if #(
    parameter int PC_WIDTH   = 8,
    parameter int FLAG_WIDTH = 8
);
    logic                  step;
    logic                  branch_valid;
    logic                  branch_ready;
    logic [1:0]            branch_op;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [FLAG_WIDTH-1:0] cmp_flag;
    logic [PC_WIDTH-1:0]   pc_out;
    logic                  done;
    logic                  taken;
    logic                  flag_error;

    modport master (
        output step, branch_valid, branch_op, branch_target, cmp_flag,
        input  branch_ready, pc_out, done, taken, flag_error
    );

    modport slave (
        input  step, branch_valid, branch_op, branch_target, cmp_flag,
        output branch_ready, pc_out, done, taken, flag_error
    );
endinterface

// File: rtl/branch_unit.sv
// branch_unit: resolves branches from the comparator flag word and owns the program counter
module branch_unit #(
    parameter int PC_WIDTH   = 8,
    parameter int FLAG_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    branch_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [PC_WIDTH-1:0]   tgt_q, tgt_d;
    logic [FLAG_WIDTH-1:0] flag_q, flag_d;
    logic                  tnx_q, tnx_d;
    logic                  err_q, err_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  taken_q, taken_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  f_true, f_false, accept;

    assign f_true           = &flag_q;
    assign f_false          = ~|flag_q;
    assign bus.branch_ready = (state_q == IDLE) && !rst;
    assign accept           = bus.branch_valid && bus.branch_ready;
    assign bus.pc_out       = pc_q;
    assign bus.done         = done_q;
    assign bus.taken        = taken_q;
    assign bus.flag_error   = ferr_q;

    // Next state plus all datapath updates; done/flag_error default low so they only pulse on commit
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        flag_d  = flag_q;
        tnx_d   = tnx_q;
        err_d   = err_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = bus.branch_op;
                    tgt_d   = bus.branch_target;
                    flag_d  = bus.cmp_flag;
                    state_d = EVAL;
                end else if (bus.step) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            EVAL: begin
                tnx_d   = (op_q == 2'b11) || (op_q == 2'b01 && f_true) || (op_q == 2'b10 && f_false);
                err_d   = (op_q[0] ^ op_q[1]) && !f_true && !f_false;
                state_d = COMMIT;
            end
            COMMIT: begin
                pc_d    = tnx_q ? tgt_q : pc_q + 1'b1;
                taken_d = tnx_q;
                done_d  = 1'b1;
                ferr_d  = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latched request, resolution result and architectural outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            tgt_q   <= '0;
            flag_q  <= '0;
            tnx_q   <= 1'b0;
            err_q   <= 1'b0;
            pc_q    <= '0;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            flag_q  <= flag_d;
            tnx_q   <= tnx_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule
